boot_seq: RTL

- Start-up sequencer directly downstream of the reset/init-done generator.
- Consumes the DDR and HDMI init-done flags, then releases the camera configuration and the video stream in a fixed order.
- Each wait phase has a timeout. A timeout pulses a sub-reset to the DDR/HDMI controllers and retries.
- After a bounded number of retries it latches a fault.

---
 rtl/boot_seq_pkg.sv | 26 ++
 rtl/boot_seq_deb.sv | 32 +++
 rtl/boot_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/boot_seq_pkg.sv
// boot_seq_pkg: shared definitions for the start-up sequencer.
//   state_t  : 3-bit state encoding exposed on boot_seq.seq_state
//   DEB_LEN  : consecutive high samples required by the optional input filter
//   RETRY_W  : width of the retry counter
//   max3     : helper used to size the phase counter
package boot_seq_pkg;

    typedef enum logic [2:0] {
        SUBRST   = 3'd0,
        WAIT_MEM = 3'd1,
        CAM_CFG  = 3'd2,
        SETTLE   = 3'd3,
        RUN      = 3'd4,
        FAULT    = 3'd5
    } state_t;

    localparam int DEB_LEN = 4;
    localparam int RETRY_W = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/boot_seq_deb.sv
// boot_seq_deb: 1-bit stable-high filter.
//   clk : system clock
//   clr : synchronous clear of the run-length counter
//   d   : raw level input
//   q   : high only once d has been sampled high DEB_LEN times in a row;
//         follows d low combinationally so deassertion is never delayed.
module boot_seq_deb
    import boot_seq_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    localparam int CW = $clog2(DEB_LEN);
    localparam logic [CW-1:0] FULL = CW'(DEB_LEN - 1);

    logic [CW-1:0] run_cnt;

    // Counts earlier consecutive high samples; the current sample is the
    // DEB_LEN-th one when the counter is already full.
    always_ff @(posedge clk) begin
        if (clr || !d)
            run_cnt <= '0;
        else if (run_cnt != FULL)
            run_cnt <= run_cnt + 1'b1;
    end

    assign q = d && (run_cnt == FULL);

endmodule

// File: rtl/boot_seq.sv
// boot_seq: start-up sequencer. Waits for DDR/HDMI init done, kicks the
// camera config engine, settles, then enables the video stream. Each wait
// has a timeout that sub-resets the controllers and retries; after
// MAX_RETRY retries a sticky fault is latched.
//   clk, rst       : clock, synchronous active-high reset
//   ddr_idone      : DDR init done (level)
//   hdmi_idone     : HDMI init done (level)
//   cam_cfg_done   : camera config complete (level)
//   sub_rst        : reset to DDR/HDMI controllers
//   cam_cfg_start  : one-cycle start pulse per CAM_CFG entry
//   stream_en      : video pipeline enable, high in RUN
//   fault          : sticky failure flag
//   retry_cnt      : failures since the last RUN entry
//   seq_state      : current state code
// Optional: define BOOT_SEQ_DEBOUNCE_EN to filter mem_ok and cam_cfg_done
// through boot_seq_deb (adds 3 cycles of rise latency).
module boot_seq
    import boot_seq_pkg::*;
#(
    parameter int RST_CYC    = 16,
    parameter int TIMEOUT    = 1000000,
    parameter int SETTLE_CYC = 1024,
    parameter int MAX_RETRY  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ddr_idone,
    input  logic               hdmi_idone,
    input  logic               cam_cfg_done,
    output logic               sub_rst,
    output logic               cam_cfg_start,
    output logic               stream_en,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         seq_state
);

    localparam int CNT_W = $clog2(max3(TIMEOUT, RST_CYC, SETTLE_CYC)) + 1;
    localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SET_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry_d;
    logic               mem_raw, mem_ok, cam_ok, fail, enter_subrst;

    assign mem_raw      = ddr_idone & hdmi_idone;
    assign enter_subrst = (nxt_state == SUBRST) && (state != SUBRST);

`ifdef BOOT_SEQ_DEBOUNCE_EN
    // Filters restart on every sub-reset so a stale run-length from before
    // the controllers were reset cannot shorten the qualification.
    boot_seq_deb u_deb_mem (
        .clk (clk),
        .clr (rst | enter_subrst),
        .d   (mem_raw),
        .q   (mem_ok)
    );
    boot_seq_deb u_deb_cam (
        .clk (clk),
        .clr (rst | enter_subrst),
        .d   (cam_cfg_done),
        .q   (cam_ok)
    );
`else
    assign mem_ok = mem_raw;
    assign cam_ok = cam_cfg_done;
`endif

    always_comb begin
        nxt_state = state;
        fail      = 1'b0;
        retry_d   = retry_cnt;
        case (state)
            SUBRST:   if (cnt == RST_LAST) nxt_state = WAIT_MEM;
            WAIT_MEM: begin
                // success is checked first so a late mem_ok wins the tie
                if (mem_ok)               nxt_state = CAM_CFG;
                else if (cnt == TO_LAST)  fail = 1'b1;
            end
            CAM_CFG: begin
                // cnt==0 is the start-pulse cycle; done from a previous
                // run is not trusted there
                if (!mem_ok)                          fail = 1'b1;
                else if (cam_ok && (cnt != '0))       nxt_state = SETTLE;
                else if (cnt == TO_LAST)              fail = 1'b1;
            end
            SETTLE: begin
                if (!mem_ok)              fail = 1'b1;
                else if (cnt == SET_LAST) nxt_state = RUN;
            end
            RUN:      if (!mem_ok) fail = 1'b1;
            FAULT:    nxt_state = FAULT;
            default:  nxt_state = SUBRST;
        endcase

        if (fail) begin
            if (retry_cnt == RETRY_MAX) begin
                nxt_state = FAULT;
            end else begin
                nxt_state = SUBRST;
                if (retry_cnt != {RETRY_W{1'b1}})
                    retry_d = retry_cnt + 1'b1;
            end
        end

        if ((nxt_state == RUN) && (state != RUN))
            retry_d = '0;
    end

    // Outputs are registered from nxt_state so they line up with seq_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SUBRST;
            cnt           <= '0;
            retry_cnt     <= '0;
            sub_rst       <= 1'b1;
            cam_cfg_start <= 1'b0;
            stream_en     <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= nxt_state;
            cnt           <= (nxt_state != state) ? '0 : cnt + 1'b1;
            retry_cnt     <= retry_d;
            sub_rst       <= (nxt_state == SUBRST) || (nxt_state == FAULT);
            cam_cfg_start <= (nxt_state == CAM_CFG) && (state != CAM_CFG);
            stream_en     <= (nxt_state == RUN);
            fault         <= (nxt_state == FAULT);
        end
    end

    assign seq_state = state;

endmodule
